// File: rtl/cook_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cook_sequencer_pkg
//  Brief    : Shared state encoding and default sizing for the microwave
//             cook-timer sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package cook_sequencer_pkg;

    // Sequencer states; READY is reserved in the encoding and never entered
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_READY = 3'd2,
        ST_COOK  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_ALARM = 3'd5
    } state_e;

    localparam int unsigned STATE_W         = 3;
    localparam int unsigned DEF_MAX_DIGITS  = 3;
    localparam int unsigned DEF_ALARM_TICKS = 5;
    localparam int unsigned DEF_CNT_W       = 3;

    // Keypad codes above 9 are not BCD digits and are discarded
    function automatic logic is_bcd(input logic [3:0] digit);
        return (digit <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cook_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : cook_sequencer_if
//  Brief    : Keypad/door/timer signal bundle around the cook sequencer.
//             master = keypad, door and timer side; slave = sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface cook_sequencer_if;

    logic       tick_1hz;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic       timer_done;
    logic [3:0] timer_digit;
    logic       timer_loadn;
    logic       timer_enable;
    logic       timer_clearn;
    logic       mag_on;
    logic       alarm;
    logic [2:0] state_o;

    modport master (
        output tick_1hz, key_valid, key_digit, startn, stopn, door_closed, timer_done,
        input  timer_digit, timer_loadn, timer_enable, timer_clearn, mag_on, alarm, state_o
    );

    modport slave (
        input  tick_1hz, key_valid, key_digit, startn, stopn, door_closed, timer_done,
        output timer_digit, timer_loadn, timer_enable, timer_clearn, mag_on, alarm, state_o
    );

endinterface
`default_nettype wire

// File: rtl/cook_sequencer_alarm_counter.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_counter
//  Brief    : Saturating up-counter with synchronous clear and a terminal
//             flag. Used both for the keypad digit count and for the
//             completion-alarm tick count.
//  Revision : 1.0  initial release
// ============================================================================
module alarm_counter #(
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned TERMINAL = 5
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr_i,
    input  wire logic inc_i,
    output logic      full_o
);

    logic [CNT_W-1:0] count_q;

    assign full_o = (count_q == CNT_W'(TERMINAL));

    // Count increments, holding at the terminal value until cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && !full_o) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cook_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cook_sequencer
//  Brief    : Control FSM for the MM:SS microwave cook timer. Loads keypad
//             digits into the timer, gates its count enable with the 1 Hz
//             tick while cooking, drives the magnetron and raises the
//             completion alarm. All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module cook_sequencer
    import cook_sequencer_pkg::*;
#(
    parameter int unsigned MAX_DIGITS  = DEF_MAX_DIGITS,
    parameter int unsigned ALARM_TICKS = DEF_ALARM_TICKS,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  wire logic        CLK,
    input  wire logic        clearn,
    cook_sequencer_if.slave  bus
);

    state_e     state_q,        state_d;
    logic       load_pend_q,    load_pend_d;
    logic [3:0] pend_digit_q,   pend_digit_d;
    logic [3:0] timer_digit_q,  timer_digit_d;
    logic       timer_loadn_q,  timer_loadn_d;
    logic       timer_enable_q, timer_enable_d;
    logic       timer_clearn_q, timer_clearn_d;
    logic       mag_on_q,       mag_on_d;
    logic       alarm_q,        alarm_d;

    logic       key_ok;
    logic       start_req;
    logic       stop_req;
    logic       dig_inc;
    logic       dig_full;
    logic       alm_inc;
    logic       alm_full;

    assign key_ok    = bus.key_valid && is_bcd(bus.key_digit);
    assign start_req = !bus.startn;
    assign stop_req  = !bus.stopn;

    // Number of digits shifted into the timer during the current entry
    alarm_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (MAX_DIGITS)
    ) u_digit_cnt (
        .clk    (CLK),
        .rst_n  (clearn),
        .clr_i  (state_d == ST_IDLE),
        .inc_i  (dig_inc),
        .full_o (dig_full)
    );

    // Ticks elapsed since the alarm was raised
    alarm_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (ALARM_TICKS)
    ) u_alarm_cnt (
        .clk    (CLK),
        .rst_n  (clearn),
        .clr_i  (state_q != ST_ALARM),
        .inc_i  (alm_inc),
        .full_o (alm_full)
    );

    // Next-state and next-output decode; stop beats door-open beats start beats key
    always_comb begin
        state_d        = state_q;
        load_pend_d    = 1'b0;
        pend_digit_d   = pend_digit_q;
        timer_digit_d  = timer_digit_q;
        timer_loadn_d  = 1'b1;
        timer_enable_d = 1'b0;
        timer_clearn_d = 1'b1;
        dig_inc        = 1'b0;
        alm_inc        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_pend_q) begin
                    // Second half of the first key: clear went out last cycle, now load
                    if (stop_req) begin
                        timer_clearn_d = 1'b0;
                    end else begin
                        timer_loadn_d = 1'b0;
                        timer_digit_d = pend_digit_q;
                        dig_inc       = 1'b1;
                        state_d       = ST_ENTRY;
                    end
                end else if (key_ok && !stop_req) begin
                    timer_clearn_d = 1'b0;
                    load_pend_d    = 1'b1;
                    pend_digit_d   = bus.key_digit;
                end
            end

            ST_ENTRY: begin
                if (stop_req) begin
                    timer_clearn_d = 1'b0;
                    state_d        = ST_IDLE;
                end else if (start_req) begin
                    // An open door blocks start; an all-zero entry abandons cooking
                    if (bus.door_closed) begin
                        state_d = bus.timer_done ? ST_IDLE : ST_COOK;
                    end
                end else if (key_ok && !dig_full) begin
                    timer_loadn_d = 1'b0;
                    timer_digit_d = bus.key_digit;
                    dig_inc       = 1'b1;
                end
            end

            ST_COOK: begin
                if (stop_req || !bus.door_closed) begin
                    state_d = ST_PAUSE;
                end else if (bus.timer_done) begin
                    state_d = ST_ALARM;
                end else begin
                    timer_enable_d = bus.tick_1hz;
                end
            end

            ST_PAUSE: begin
                if (stop_req) begin
                    timer_clearn_d = 1'b0;
                    state_d        = ST_IDLE;
                end else if (start_req && bus.door_closed) begin
                    state_d = ST_COOK;
                end
            end

            ST_ALARM: begin
                if (stop_req || !bus.door_closed || alm_full) begin
                    state_d = ST_IDLE;
                end else begin
                    alm_inc = bus.tick_1hz;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered output stage; reset forces safe outputs immediately
    always_ff @(posedge CLK or negedge clearn) begin
        if (!clearn) begin
            state_q        <= ST_IDLE;
            load_pend_q    <= 1'b0;
            pend_digit_q   <= 4'd0;
            timer_digit_q  <= 4'd0;
            timer_loadn_q  <= 1'b1;
            timer_enable_q <= 1'b0;
            timer_clearn_q <= 1'b1;
            mag_on_q       <= 1'b0;
            alarm_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_pend_q    <= load_pend_d;
            pend_digit_q   <= pend_digit_d;
            timer_digit_q  <= timer_digit_d;
            timer_loadn_q  <= timer_loadn_d;
            timer_enable_q <= timer_enable_d;
            timer_clearn_q <= timer_clearn_d;
            mag_on_q       <= (state_d == ST_COOK);
            alarm_q        <= (state_d == ST_ALARM);
        end
    end

    assign bus.timer_digit  = timer_digit_q;
    assign bus.timer_loadn  = timer_loadn_q;
    assign bus.timer_enable = timer_enable_q;
    assign bus.timer_clearn = timer_clearn_q;
    assign bus.mag_on       = mag_on_q;
    assign bus.alarm        = alarm_q;
    assign bus.state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cook_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cook_sequencer
//  Brief    : Self-checking bench for cook_sequencer. Directed scenarios plus
//             randomized cook cycles, compared against expectations derived
//             from the keypad/cook/alarm rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cook_sequencer;

    localparam int MAXD    = 3;
    localparam int ALARM_N = 5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTRY = 3'd1;
    localparam logic [2:0] S_COOK  = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_ALARM = 3'd5;

    logic CLK;
    logic clearn;

    cook_sequencer_if bus();

    cook_sequencer #(
        .MAX_DIGITS  (MAXD),
        .ALARM_TICKS (ALARM_N),
        .CNT_W       (3)
    ) dut (
        .CLK    (CLK),
        .clearn (clearn),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor: observed timer-side events ----------------
    logic [3:0] load_q[$];
    int         n_enable     = 0;
    int         n_clear      = 0;
    int         n_bad_enable = 0;
    int         n_overlap    = 0;
    logic       tick_prev    = 1'b0;

    always @(negedge CLK) begin
        if (clearn) begin
            if (!bus.timer_loadn) load_q.push_back(bus.timer_digit);
            if (bus.timer_enable) begin
                n_enable <= n_enable + 1;
                if (!tick_prev) n_bad_enable <= n_bad_enable + 1;
            end
            if (!bus.timer_clearn) n_clear <= n_clear + 1;
            if (!bus.timer_loadn && bus.timer_enable) n_overlap <= n_overlap + 1;
            tick_prev <= bus.tick_1hz;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        step();
        bus.key_valid = 1'b0;
    endtask

    task automatic start_p();
        bus.startn = 1'b0;
        step();
        bus.startn = 1'b1;
    endtask

    task automatic stop_p();
        bus.stopn = 1'b0;
        step();
        bus.stopn = 1'b1;
    endtask

    task automatic tick_p();
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
    endtask

    task automatic gap(input int lo, input int hi);
        repeat ($urandom_range(hi, lo)) step();
    endtask

    // Raise completion from COOK and let the alarm run its full course
    task automatic alarm_run(input string tag);
        int w;
        bus.timer_done = 1'b1;
        step();
        chk({tag, "_alarm_state"}, bus.state_o, S_ALARM);
        chk({tag, "_alarm_mag"},   bus.mag_on,  1'b0);
        for (int t = 0; t < ALARM_N; t++) begin
            gap(1, 3);
            chk({tag, "_alarm_hold"}, bus.alarm, 1'b1);
            tick_p();
        end
        w = 0;
        while (bus.state_o != S_IDLE && w < 3) begin
            step();
            w++;
        end
        chk({tag, "_alarm_exit"}, bus.state_o, S_IDLE);
        chk({tag, "_alarm_off"},  bus.alarm,   1'b0);
        bus.timer_done = 1'b0;
        step();
    endtask

    // Watchdog so a stuck run still ends with a report
    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int e0;
        int c0;
        logic [3:0] exp_loads[$];

        bus.tick_1hz    = 1'b0;
        bus.key_valid   = 1'b0;
        bus.key_digit   = 4'd0;
        bus.startn      = 1'b1;
        bus.stopn       = 1'b1;
        bus.door_closed = 1'b1;
        bus.timer_done  = 1'b0;
        clearn          = 1'b0;

        // Reset values
        repeat (2) step();
        chk("rst_state",  bus.state_o,      S_IDLE);
        chk("rst_loadn",  bus.timer_loadn,  1'b1);
        chk("rst_enable", bus.timer_enable, 1'b0);
        chk("rst_clearn", bus.timer_clearn, 1'b1);
        chk("rst_mag",    bus.mag_on,       1'b0);
        chk("rst_alarm",  bus.alarm,        1'b0);
        chk("rst_digit",  bus.timer_digit,  4'd0);
        @(negedge CLK);
        clearn = 1'b1;
        step();

        // Keys 1,3,0 then start
        press(4'd1);
        chk("t1_clear_pulse", bus.timer_clearn, 1'b0);
        chk("t1_no_load_yet", bus.timer_loadn,  1'b1);
        step();
        chk("t1_load1",  bus.timer_loadn, 1'b0);
        chk("t1_dig1",   bus.timer_digit, 4'd1);
        chk("t1_entry",  bus.state_o,     S_ENTRY);
        chk("t1_clr_end", bus.timer_clearn, 1'b1);
        step();
        press(4'd3);
        chk("t1_load3", bus.timer_loadn, 1'b0);
        chk("t1_dig3",  bus.timer_digit, 4'd3);
        step();
        press(4'd0);
        chk("t1_load0", bus.timer_loadn, 1'b0);
        chk("t1_dig0",  bus.timer_digit, 4'd0);
        step();
        start_p();
        chk("t1_cook", bus.state_o, S_COOK);
        chk("t1_mag",  bus.mag_on,  1'b1);

        // Three ticks in COOK
        e0 = n_enable;
        for (int t = 0; t < 3; t++) begin
            gap(1, 3);
            tick_p();
            chk("t2_enable_follows_tick", bus.timer_enable, 1'b1);
        end
        step();
        chk("t2_enable_count", n_enable - e0, 3);

        // Door opens together with a tick
        e0 = n_enable;
        bus.door_closed = 1'b0;
        bus.tick_1hz    = 1'b1;
        step();
        bus.tick_1hz    = 1'b0;
        chk("t3_pause", bus.state_o, S_PAUSE);
        chk("t3_mag",   bus.mag_on,  1'b0);
        gap(1, 2);
        tick_p();
        step();
        chk("t3_no_enable", n_enable - e0, 0);
        start_p();
        chk("t3_start_door_open", bus.state_o, S_PAUSE);
        bus.door_closed = 1'b1;
        step();
        start_p();
        chk("t3_resume", bus.state_o, S_COOK);
        chk("t3_resume_mag", bus.mag_on, 1'b1);
        stop_p();
        chk("t3_stop_pause", bus.state_o, S_PAUSE);
        start_p();
        chk("t3_resume2", bus.state_o, S_COOK);

        // Completion alarm
        alarm_run("t4");

        // Invalid key in IDLE, then four digits, then 0xA, then start with door open
        c0 = n_clear;
        press(4'hA);
        step();
        chk("t5_hex_idle_state", bus.state_o, S_IDLE);
        chk("t5_hex_idle_clear", n_clear - c0, 0);
        load_q.delete();
        press(4'd1); step();
        press(4'd2); step();
        press(4'd3); step();
        press(4'd4); step();
        press(4'hA); step();
        chk("t5_load_count", load_q.size(), MAXD);
        if (load_q.size() == MAXD) begin
            chk("t5_l0", load_q[0], 4'd1);
            chk("t5_l1", load_q[1], 4'd2);
            chk("t5_l2", load_q[2], 4'd3);
        end
        bus.door_closed = 1'b0;
        start_p();
        chk("t5_stay_entry", bus.state_o, S_ENTRY);
        chk("t5_no_mag",     bus.mag_on,  1'b0);
        bus.door_closed = 1'b1;
        step();

        // Start and stop together during ENTRY
        bus.startn = 1'b0;
        bus.stopn  = 1'b0;
        step();
        bus.startn = 1'b1;
        bus.stopn  = 1'b1;
        chk("t6_clear", bus.timer_clearn, 1'b0);
        chk("t6_idle",  bus.state_o,      S_IDLE);
        step();

        // All-zero entry: start with timer_done returns to IDLE
        press(4'd0); step();
        bus.timer_done = 1'b1;
        start_p();
        chk("t7_zero_idle", bus.state_o, S_IDLE);
        chk("t7_zero_mag",  bus.mag_on,  1'b0);
        bus.timer_done = 1'b0;
        step();

        // Randomized cook cycles against expectations built from the rules
        for (int it = 0; it < 12; it++) begin
            int nk;
            int nt;
            int ending;
            logic [3:0] d;
            exp_loads.delete();
            load_q.delete();
            c0 = n_clear;
            nk = $urandom_range(5, 1);
            for (int k = 0; k < nk; k++) begin
                d = 4'($urandom_range(15, 0));
                if (d <= 4'd9 && exp_loads.size() < MAXD) exp_loads.push_back(d);
                press(d);
                gap(1, 3);
            end
            chk("rnd_clear_pulses", n_clear - c0, (exp_loads.size() > 0) ? 1 : 0);
            chk("rnd_load_count", load_q.size(), exp_loads.size());
            if (load_q.size() == exp_loads.size()) begin
                for (int i = 0; i < exp_loads.size(); i++) begin
                    chk("rnd_load_digit", load_q[i], exp_loads[i]);
                end
            end
            if (exp_loads.size() == 0) begin
                chk("rnd_stay_idle", bus.state_o, S_IDLE);
                continue;
            end
            chk("rnd_entry", bus.state_o, S_ENTRY);
            start_p();
            chk("rnd_cook", bus.state_o, S_COOK);
            e0 = n_enable;
            nt = $urandom_range(4, 1);
            for (int t = 0; t < nt; t++) begin
                gap(1, 3);
                tick_p();
            end
            step();
            chk("rnd_enable_count", n_enable - e0, nt);
            chk("rnd_mag_cook", bus.mag_on, 1'b1);

            ending = $urandom_range(2, 0);
            if (ending == 0) begin
                bus.door_closed = 1'b0;
                step();
                chk("rnd_pause", bus.state_o, S_PAUSE);
                e0 = n_enable;
                tick_p();
                step();
                chk("rnd_pause_no_enable", n_enable - e0, 0);
                bus.door_closed = 1'b1;
                stop_p();
                chk("rnd_stop_clear", bus.timer_clearn, 1'b0);
                chk("rnd_stop_idle",  bus.state_o,      S_IDLE);
                step();
            end else if (ending == 1) begin
                alarm_run("rnd");
            end else begin
                nt = $urandom_range(ALARM_N - 1, 0);
                bus.timer_done = 1'b1;
                step();
                chk("rnd_alarm", bus.alarm, 1'b1);
                for (int t = 0; t < nt; t++) begin
                    gap(1, 2);
                    tick_p();
                end
                step();
                chk("rnd_alarm_hold", bus.alarm, 1'b1);
                bus.door_closed = 1'b0;
                step();
                chk("rnd_door_idle",  bus.state_o, S_IDLE);
                chk("rnd_door_alarm", bus.alarm,   1'b0);
                bus.door_closed = 1'b1;
                bus.timer_done  = 1'b0;
                step();
            end
        end

        // Asynchronous reset in the middle of a COOK cycle
        press(4'd5); step();
        start_p();
        chk("t8_cook", bus.mag_on, 1'b1);
        @(posedge CLK);
        #2;
        clearn = 1'b0;
        #1;
        chk("t8_mag",    bus.mag_on,       1'b0);
        chk("t8_state",  bus.state_o,      S_IDLE);
        chk("t8_loadn",  bus.timer_loadn,  1'b1);
        chk("t8_enable", bus.timer_enable, 1'b0);
        chk("t8_clearn", bus.timer_clearn, 1'b1);
        chk("t8_alarm",  bus.alarm,        1'b0);
        chk("t8_digit",  bus.timer_digit,  4'd0);
        @(negedge CLK);
        clearn = 1'b1;
        step();

        chk("glob_enable_timing", n_bad_enable, 0);
        chk("glob_load_enable_overlap", n_overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
